// File: rtl/exec_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the execution stage.
// Shift-add multiplier (MUL_BPC bits per cycle), restoring divider, divide fast paths and DIV/REM reuse.
module exec_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_BPC  = 4,
    parameter bit REUSE_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            stall_o
);
    localparam int MUL_STEPS = XLEN / MUL_BPC;
    localparam int CNT_W     = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STEPS);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [2:0]          op_reg;
    logic                neg_q_reg;
    logic                neg_r_reg;
    logic [XLEN-1:0]     a_reg;
    logic [XLEN-1:0]     b_reg;
    logic [XLEN-1:0]     mcand_reg;
    logic [XLEN-1:0]     rem_reg;
    logic [2*XLEN-1:0]   acc_reg;
    logic                valid_reg;
    logic [XLEN-1:0]     result_reg;
    logic                cache_valid_reg;
    logic                cache_signed_reg;
    logic [XLEN-1:0]     cache_a_reg;
    logic [XLEN-1:0]     cache_b_reg;
    logic [XLEN-1:0]     cache_quot_reg;
    logic [XLEN-1:0]     cache_rem_reg;

    // Request decode: signedness per operand, magnitudes and divide fast paths
    logic            in_is_div;
    logic            in_is_rem;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            reuse_hit;
    logic            fast_path;
    logic [XLEN-1:0] fast_result;

    always_comb begin
        in_is_div = op_i[2];
        in_is_rem = op_i[1];
        a_signed  = in_is_div ? ~op_i[0] : (op_i[1] ^ op_i[0]);
        b_signed  = in_is_div ? ~op_i[0] : (op_i[1:0] == 2'b01);
        a_neg     = a_signed & a_i[XLEN-1];
        b_neg     = b_signed & b_i[XLEN-1];
        a_mag     = a_neg ? -a_i : a_i;
        b_mag     = b_neg ? -b_i : b_i;
        div_zero  = (b_i == '0);
        div_ovf   = ~op_i[0] & (a_i == MOST_NEG) & (b_i == '1);
        reuse_hit = REUSE_EN & cache_valid_reg & (cache_a_reg == a_i) & (cache_b_reg == b_i)
                    & (cache_signed_reg == ~op_i[0]);
        fast_path = in_is_div & (div_zero | div_ovf | reuse_hit);
        if (div_zero) begin
            fast_result = in_is_rem ? a_i : '1;
        end else if (div_ovf) begin
            fast_result = in_is_rem ? '0 : a_i;
        end else begin
            fast_result = in_is_rem ? cache_rem_reg : cache_quot_reg;
        end
    end

    // Multiplier step: upper half accumulates mcand * low MUL_BPC multiplier bits, then shifts right
    logic [XLEN+MUL_BPC-1:0] pp [MUL_BPC];
    logic [XLEN+MUL_BPC-1:0] mul_sum;

    genvar gi;
    generate
        for (gi = 0; gi < MUL_BPC; gi++) begin : g_pp
            assign pp[gi] = acc_reg[gi] ? ({{MUL_BPC{1'b0}}, mcand_reg} << gi) : '0;
        end
    endgenerate

    always_comb begin
        mul_sum = {{MUL_BPC{1'b0}}, acc_reg[2*XLEN-1:XLEN]};
        for (int i = 0; i < MUL_BPC; i++) begin
            mul_sum = mul_sum + pp[i];
        end
    end

    // Divider step: the quotient shifts in at the bottom of acc_reg as the dividend shifts out the top
    logic [XLEN:0]   rem_shift;
    logic            rem_ge;
    logic [XLEN-1:0] rem_sub;

    assign rem_shift = {rem_reg, acc_reg[XLEN-1]};
    assign rem_ge    = rem_shift >= {1'b0, mcand_reg};
    assign rem_sub   = rem_shift[XLEN-1:0] - mcand_reg;

    // Sign fix applied on the final CALC cycle
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   calc_result;
    logic [CNT_W-1:0]  cnt_last;

    always_comb begin
        prod_fix = neg_q_reg ? -acc_reg : acc_reg;
        quot_fix = neg_q_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
        rem_fix  = neg_r_reg ? -rem_reg : rem_reg;
        if (op_reg[2]) begin
            calc_result = op_reg[1] ? rem_fix : quot_fix;
        end else begin
            calc_result = (op_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
        cnt_last = op_reg[2] ? DIV_LAST : MUL_LAST;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            op_reg           <= '0;
            neg_q_reg        <= 1'b0;
            neg_r_reg        <= 1'b0;
            a_reg            <= '0;
            b_reg            <= '0;
            mcand_reg        <= '0;
            rem_reg          <= '0;
            acc_reg          <= '0;
            valid_reg        <= 1'b0;
            result_reg       <= '0;
            cache_valid_reg  <= 1'b0;
            cache_signed_reg <= 1'b0;
            cache_a_reg      <= '0;
            cache_b_reg      <= '0;
            cache_quot_reg   <= '0;
            cache_rem_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid_i && !flush_i) begin
                        cnt_reg   <= '0;
                        op_reg    <= op_i;
                        a_reg     <= a_i;
                        b_reg     <= b_i;
                        neg_q_reg <= a_neg ^ b_neg;
                        neg_r_reg <= a_neg;
                        mcand_reg <= in_is_div ? b_mag : a_mag;
                        acc_reg   <= {{XLEN{1'b0}}, (in_is_div ? a_mag : b_mag)};
                        rem_reg   <= '0;
                        if (fast_path) begin
                            result_reg <= fast_result;
                            valid_reg  <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg == cnt_last) begin
                        result_reg <= calc_result;
                        valid_reg  <= 1'b1;
                        state_reg  <= DONE;
                        if (op_reg[2]) begin
                            cache_valid_reg  <= 1'b1;
                            cache_signed_reg <= ~op_reg[0];
                            cache_a_reg      <= a_reg;
                            cache_b_reg      <= b_reg;
                            cache_quot_reg   <= quot_fix;
                            cache_rem_reg    <= rem_fix;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (op_reg[2]) begin
                            rem_reg <= rem_ge ? rem_sub : rem_shift[XLEN-1:0];
                            acc_reg <= {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-2:0], rem_ge};
                        end else begin
                            acc_reg <= {mul_sum, acc_reg[XLEN-1:MUL_BPC]};
                        end
                    end
                end
                DONE: begin
                    if (flush_i || ready_i) begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready_o  = (state_reg == IDLE);
    assign valid_o  = valid_reg;
    assign result_o = result_reg;
    assign stall_o  = (state_reg != IDLE) || valid_i;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Directed bench for exec_muldiv_unit: arithmetic reference model checked every cycle,
// plus literal result/latency expectations per directed operation.
module tb_exec_muldiv_unit;
    localparam int MUL_LAT  = 9;   // edges after the accepting edge until valid_o is seen
    localparam int DIV_LAT  = 33;
    localparam int FAST_LAT = 0;   // fast-path result is visible right after the accepting edge

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  op_i = '0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        flush_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] result_o;
    logic        stall_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    exec_muldiv_unit #(.XLEN(32), .MUL_BPC(4), .REUSE_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on 64-bit values
    function automatic logic [31:0] ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] ua, ub, up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            OP_MUL:    begin up = ua * ub; return up[31:0]; end
            OP_MULH:   begin sp = sa * sb; return sp[63:32]; end
            OP_MULHSU: begin sp = sa * $signed(ub); return sp[63:32]; end
            OP_MULHU:  begin up = ua * ub; return up[63:32]; end
            OP_DIV:    begin if (b == 0) return '1; sp = sa / sb; return sp[31:0]; end
            OP_DIVU:   begin if (b == 0) return '1; up = ua / ub; return up[31:0]; end
            OP_REM:    begin if (b == 0) return a; sp = sa % sb; return sp[31:0]; end
            default:   begin if (b == 0) return a; up = ua % ub; return up[31:0]; end
        endcase
    endfunction

    // Model state: last completed normal division
    bit          c_ok = 1'b0;
    bit          c_signed = 1'b0;
    logic [31:0] c_a = '0;
    logic [31:0] c_b = '0;

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit is_signed;
        is_signed = (op == OP_DIV) || (op == OP_REM);
        if (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) return MUL_LAT;
        if (b == 0) return FAST_LAT;
        if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return FAST_LAT;
        if (c_ok && c_a == a && c_b == b && c_signed == is_signed) return FAST_LAT;
        return DIV_LAT;
    endfunction

    bit          m_idle = 1'b1;
    bit          m_valid = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res = '0;
    logic [31:0] p_res = '0;
    bit          p_div = 1'b0;
    bit          p_signed = 1'b0;
    logic [31:0] p_a = '0;
    logic [31:0] p_b = '0;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_idle  <= 1'b1;
            m_valid <= 1'b0;
            m_left  <= 0;
            m_res   <= '0;
            c_ok    <= 1'b0;
        end else if (m_idle) begin
            if (valid_i && !flush_i) begin
                m_idle   <= 1'b0;
                p_res    <= ref_calc(op_i, a_i, b_i);
                p_div    <= (op_i[2] == 1'b1);
                p_signed <= (op_i == OP_DIV) || (op_i == OP_REM);
                p_a      <= a_i;
                p_b      <= b_i;
                if (model_lat(op_i, a_i, b_i) == FAST_LAT) begin
                    m_valid <= 1'b1;
                    m_res   <= ref_calc(op_i, a_i, b_i);
                end else begin
                    m_left <= model_lat(op_i, a_i, b_i);
                end
            end
        end else if (!m_valid) begin
            if (flush_i) begin
                m_idle <= 1'b1;
            end else if (m_left == 1) begin
                m_valid <= 1'b1;
                m_res   <= p_res;
                if (p_div) begin
                    c_ok     <= 1'b1;
                    c_a      <= p_a;
                    c_b      <= p_b;
                    c_signed <= p_signed;
                end
            end else begin
                m_left <= m_left - 1;
            end
        end else if (flush_i || ready_i) begin
            m_idle  <= 1'b1;
            m_valid <= 1'b0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk_i) begin
        if (chk_en && !rst_i) begin
            check("valid_o", valid_o, m_valid);
            check("ready_o", ready_o, m_idle);
            check("stall_o", stall_o, (!m_idle) || valid_i);
            if (m_valid) check("result_o", result_o, m_res);
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Issue one operation, measure latency, hold ready_i low for 'hold' cycles, then handshake
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                          input int hold);
        int n;
        op_i = op; a_i = a; b_i = b; valid_i = 1'b1; ready_i = 1'b0;
        tick();
        valid_i = 1'b0;
        n = 0;
        while (!valid_o && n < 100) begin
            tick();
            n++;
        end
        check({name, " latency"}, n, exp_lat);
        check({name, " result"}, result_o, exp_res);
        repeat (hold) tick();
        check({name, " held result"}, result_o, exp_res);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check({name, " ready after handshake"}, ready_o, 1'b1);
        $display("op %s a=%h b=%h result=%h latency=%0d", name, a, b, result_o, n);
    endtask

    initial begin
        int seen;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        repeat (3) tick();
        check("reset ready_o", ready_o, 1'b1);
        check("reset valid_o", valid_o, 1'b0);
        check("reset result_o", result_o, 32'h0);
        check("reset stall_o", stall_o, 1'b0);
        rst_i = 1'b0;
        chk_en = 1'b1;
        tick();

        run_op("MUL", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 0);
        run_op("MULH", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 0);
        run_op("MULHU", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 0);
        run_op("MULHSU", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT, 0);
        run_op("DIV -20/3", OP_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, DIV_LAT, 0);
        run_op("REM -20/3 reuse", OP_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, FAST_LAT, 0);
        run_op("REMU no reuse", OP_REMU, 32'hFFFF_FFEC, 32'd3, 32'd2, DIV_LAT, 0);
        run_op("DIVU 5/0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, FAST_LAT, 0);
        run_op("REM 5/0", OP_REM, 32'd5, 32'd0, 32'd5, FAST_LAT, 0);
        run_op("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FAST_LAT, 0);
        run_op("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, FAST_LAT, 0);

        // Flush in IDLE suppresses the accept
        op_i = OP_DIV; a_i = 32'd9; b_i = 32'd3; valid_i = 1'b1; flush_i = 1'b1;
        tick();
        valid_i = 1'b0; flush_i = 1'b0;
        check("idle flush no accept", ready_o, 1'b1);
        $display("op idle-flush DIV 9/3 ready_o=%0b", ready_o);

        // Flush mid-division
        op_i = OP_DIV; a_i = 32'd100; b_i = 32'd7; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush ready_o", ready_o, 1'b1);
        check("flush valid_o", valid_o, 1'b0);
        seen = 0;
        repeat (40) begin
            tick();
            if (valid_o) seen++;
        end
        check("flush no result", seen, 0);
        $display("op flushed DIV 100/7 valid_seen=%0d", seen);
        run_op("REM 100/7 after flush", OP_REM, 32'd100, 32'd7, 32'd2, DIV_LAT, 0);

        run_op("MUL 3x4 backpressure", OP_MUL, 32'd3, 32'd4, 32'd12, MUL_LAT, 3);
        run_op("DIV -20/3 again", OP_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, DIV_LAT, 0);

        // Reset mid-CALC also clears the reuse cache
        op_i = OP_MUL; a_i = 32'd3; b_i = 32'd4; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (3) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid reset valid_o", valid_o, 1'b0);
        check("mid reset ready_o", ready_o, 1'b1);
        check("mid reset result_o", result_o, 32'h0);
        $display("op reset mid-CALC valid_o=%0b ready_o=%0b result_o=%h", valid_o, ready_o, result_o);
        run_op("REM -20/3 after reset", OP_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, DIV_LAT, 0);

        // A multiply in between keeps the cache alive
        run_op("MUL 2x3", OP_MUL, 32'd2, 32'd3, 32'd6, MUL_LAT, 0);
        run_op("DIV -20/3 reuse after MUL", OP_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, FAST_LAT, 1);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
